stream_demux_1_4: RTL and testbench
===================================

# stream_demux_1_4

Registered 1-to-4 stream demultiplexer: the reverse direction of the team's 4:1 data mux. Each input word, tagged with a 2-bit select, is steered to one of four output lanes under valid/ready flow control. Each lane carries its own 2-entry buffer, so a stalled lane never blocks traffic to the others once the word for it has been accepted. The block sits between a single producer and four independent consumers.

## Interface

- `WIDTH`, 4: data bits per word.
- `clk`, input, 1: sole clock; all state updates on posedge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: producer offers `in_data` / `in_sel`.
- `in_ready`, output, 1: block can accept the offered word.
- `in_data`, input, WIDTH: word to route.
- `in_sel`, input, 2: destination lane 0..3.
- `out_valid`, output, 4: bit k means lane k presents a word.
- `out_ready`, input, 4: bit k means consumer k takes the word.
- `out_data`, output, 4 x WIDTH (packed `[3:0][WIDTH-1:0]`): head word of each lane.

## Operation

- Input transfer: `in_valid && in_ready` at a posedge. The word is pushed into lane `in_sel`.
- `in_ready` = lane[`in_sel`] not full. It is combinational from `in_sel` and lane state only, never from `out_ready`.
- `in_ready` may be high while `in_valid` is low.
- Output transfer on lane k: `out_valid[k] && out_ready[k]` at a posedge. Pops the lane head.
- Each lane is a 2-entry FIFO with states EMPTY(0) -> ONE(1) -> FULL(2):
  - EMPTY, push: ONE.
  - ONE: push only -> FULL; pop only -> EMPTY; push and pop -> ONE, and the new word becomes head on the next cycle.
  - FULL: pop -> ONE. No push is possible because `in_ready` is low for this lane.
- `out_valid[k]` = lane k not EMPTY. `out_data[k]` = lane k head, registered; it is undefined (don't-care) when EMPTY.
- Per-lane order is preserved. Lanes are fully independent. Pops on any subset of lanes may coincide with a push to any lane.
- Data bits pass through unmodified, including X/Z.
- `in_sel` containing X while `in_valid` is high is a producer error; behaviour is unspecified.
- Reset: all lanes EMPTY, `out_valid` = 4'b0000, `in_ready` = 1, `out_data` = 0. Reset mid-operation discards all buffered words in the same posedge, with no output transfers in that cycle.

## Timing

- Latency is 1 cycle. A word accepted at edge N drives `out_valid` / `out_data` from just after edge N. It can be popped at edge N+1 at the earliest.
- Throughput: one input word per cycle, sustained indefinitely to a lane whose consumer holds `out_ready` high.
- Backpressure: lane k reaches FULL after two unpopped pushes. The third word to lane k waits with `in_ready` = 0. It is accepted the cycle after the first pop of lane k.
- No combinational path from `out_ready` to `in_ready`, or from `in_*` to `out_*`.

## Structure

- Package `stream_demux_pkg`:
  - `N_LANES` = 4.
  - `typedef logic [1:0] lane_sel_t`.
  - lane occupancy enum `lane_state_t` {EMPTY, ONE, FULL}.
- Sub-module `lane_fifo_2`: 2-entry FIFO with push/pop/full/empty, head data output, and sync reset. It is instantiated `N_LANES` times by a generate loop.
- Top level holds the select decode (one-hot push enable) and the `in_ready` mux.

## Test plan

- After reset, hold `rst` and check `out_valid` = 0 and `in_ready` = 1. Release reset, push 'ha sel 0, 'hb sel 1, 'hc sel 2, 'hd sel 3 with all `out_ready` = 1 -> each appears exactly once on its lane, one cycle after acceptance.
- `out_ready[2]` = 0; push 3, 5, 7 to sel 2 -> 3 and 5 accepted, `in_ready` drops for the third word. Raise `out_ready[2]` -> lane 2 delivers 3, 5, 7 in order, and 7 is accepted the cycle after the first pop.
- With lane 1 FULL and stalled, push 'h9 to sel 0 -> accepted immediately and delivered on lane 0. Lane 1 is unchanged.
- With lane 3 in ONE state holding 'h4: in one cycle push 'h6 to sel 3 and pop lane 3 -> lane 3 stays ONE and presents 'h6 next.
- Push 'x data to sel 1 -> `out_data[1]` is 'x with `out_valid[1]` = 1.
- Fill lanes 0 and 2, then assert `rst` for one cycle mid-stream -> all `out_valid` = 0, `in_ready` = 1, and no stale words appear afterwards.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared types for the 1-to-4 stream demultiplexer: lane count, lane select
// and per-lane occupancy encoding.
package stream_demux_pkg;

  localparam int N_LANES = 4;

  typedef logic [1:0] lane_sel_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } lane_state_t;

endpackage

// File: rtl/lane_fifo_2.sv
// Two-entry FIFO for one demux lane. The head word is held in a register so
// data_o never depends combinationally on push or data inputs.
module lane_fifo_2
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] data_o
);

  lane_state_t      state_q;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;

  // Occupancy FSM with head/tail storage; pop is ignored while EMPTY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push_i) begin
            head_q  <= data_i;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (push_i && pop_i) begin
            head_q <= data_i;
          end else if (push_i) begin
            tail_q  <= data_i;
            state_q <= FULL;
          end else if (pop_i) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (pop_i) begin
            head_q  <= tail_q;
            state_q <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign full_o  = (state_q == FULL);
  assign empty_o = (state_q == EMPTY);
  assign data_o  = head_q;

endmodule

// File: rtl/stream_demux_1_4.sv
// Registered 1-to-4 stream demultiplexer: steers each accepted word into the
// 2-entry FIFO of the lane named by in_sel.
module stream_demux_1_4
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  input  lane_sel_t                     in_sel,
  output logic [N_LANES-1:0]            out_valid,
  input  logic [N_LANES-1:0]            out_ready,
  output logic [N_LANES-1:0][WIDTH-1:0] out_data
);

  logic [N_LANES-1:0] push_en_s;
  logic [N_LANES-1:0] full_s;
  logic [N_LANES-1:0] empty_s;

  // Acceptance depends only on the selected lane's stored state.
  always_comb begin
    in_ready = ~full_s[in_sel];
  end

  // One-hot push enable for the addressed lane on an input transfer.
  always_comb begin
    push_en_s = 4'b0000;
    if (in_valid && in_ready) begin
      case (in_sel)
        2'd0:    push_en_s = 4'b0001;
        2'd1:    push_en_s = 4'b0010;
        2'd2:    push_en_s = 4'b0100;
        2'd3:    push_en_s = 4'b1000;
        default: push_en_s = 4'b0000;
      endcase
    end else begin
      push_en_s = 4'b0000;
    end
  end

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    lane_fifo_2 #(
      .WIDTH(WIDTH)
    ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push_i (push_en_s[k]),
      .data_i (in_data),
      .pop_i  (out_ready[k]),
      .full_o (full_s[k]),
      .empty_o(empty_s[k]),
      .data_o (out_data[k])
    );
    assign out_valid[k] = ~empty_s[k];
  end

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Directed self-checking bench for stream_demux_1_4.
module tb_stream_demux_1_4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_data;
  logic [1:0]      in_sel;
  logic [3:0]      out_valid;
  logic [3:0]      out_ready;
  logic [3:0][3:0] out_data;

  int checks = 0;
  int errors = 0;
  logic [3:0] xval;

  stream_demux_1_4 #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    xval      = 'x;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    in_sel    = 2'd0;
    out_ready = 4'hF;
    tick();
    tick();
    chk("rst_out_valid", 16'(out_valid), 16'h0);
    chk("rst_in_ready", 16'(in_ready), 16'h1);
    chk("rst_out_data", out_data, 16'h0000);

    // Basic routing with all consumers ready
    rst = 1'b0;
    in_valid = 1'b1; in_data = 4'ha; in_sel = 2'd0;
    #1 chk("ready_sel0", 16'(in_ready), 16'h1);
    tick();
    chk("a_valid", 16'(out_valid), 16'h1);
    chk("a_data", 16'(out_data[0]), 16'ha);
    in_data = 4'hb; in_sel = 2'd1;
    tick();
    chk("b_valid", 16'(out_valid), 16'h2);
    chk("b_data", 16'(out_data[1]), 16'hb);
    in_data = 4'hc; in_sel = 2'd2;
    tick();
    chk("c_valid", 16'(out_valid), 16'h4);
    chk("c_data", 16'(out_data[2]), 16'hc);
    in_data = 4'hd; in_sel = 2'd3;
    tick();
    chk("d_valid", 16'(out_valid), 16'h8);
    chk("d_data", 16'(out_data[3]), 16'hd);
    in_valid = 1'b0;
    tick();
    chk("route_drained", 16'(out_valid), 16'h0);

    // Backpressure on lane 2
    out_ready = 4'b1011;
    in_valid = 1'b1; in_sel = 2'd2; in_data = 4'h3;
    tick();
    chk("bp_one_valid", 16'(out_valid), 16'h4);
    chk("bp_one_data", 16'(out_data[2]), 16'h3);
    in_data = 4'h5;
    tick();
    chk("bp_full_head", 16'(out_data[2]), 16'h3);
    in_data = 4'h7;
    #1 chk("bp_ready_low", 16'(in_ready), 16'h0);
    tick();
    chk("bp_stall_head", 16'(out_data[2]), 16'h3);
    chk("bp_stall_ready", 16'(in_ready), 16'h0);
    out_ready = 4'hF;
    tick();
    chk("bp_pop1_head", 16'(out_data[2]), 16'h5);
    chk("bp_pop1_ready", 16'(in_ready), 16'h1);
    tick();
    chk("bp_7_head", 16'(out_data[2]), 16'h7);
    chk("bp_7_valid", 16'(out_valid), 16'h4);
    in_valid = 1'b0;
    tick();
    chk("bp_drained", 16'(out_valid), 16'h0);

    // Lane 1 full and stalled; lane 0 still flows
    out_ready = 4'b1101;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 4'h1;
    tick();
    in_data = 4'h2;
    tick();
    chk("l1_full_ready", 16'(in_ready), 16'h0);
    in_sel = 2'd0; in_data = 4'h9;
    #1 chk("l0_ready", 16'(in_ready), 16'h1);
    tick();
    chk("l0_valid", 16'(out_valid), 16'h3);
    chk("l0_data", 16'(out_data[0]), 16'h9);
    chk("l1_kept", 16'(out_data[1]), 16'h1);
    in_valid = 1'b0;
    tick();
    chk("l0_popped", 16'(out_valid), 16'h2);
    chk("l1_still", 16'(out_data[1]), 16'h1);
    out_ready = 4'hF;
    tick();
    chk("l1_second", 16'(out_data[1]), 16'h2);
    tick();
    chk("l1_drained", 16'(out_valid), 16'h0);

    // Lane 3 simultaneous push and pop in ONE state
    out_ready = 4'h0;
    in_valid = 1'b1; in_sel = 2'd3; in_data = 4'h4;
    tick();
    chk("l3_one", 16'(out_data[3]), 16'h4);
    in_data = 4'h6; out_ready = 4'b1000;
    tick();
    chk("l3_pp_valid", 16'(out_valid), 16'h8);
    chk("l3_pp_data", 16'(out_data[3]), 16'h6);
    in_valid = 1'b0;
    tick();
    chk("l3_drained", 16'(out_valid), 16'h0);

    // Unknown data passes through
    out_ready = 4'h0;
    in_valid = 1'b1; in_sel = 2'd1; in_data = xval;
    tick();
    chk("x_valid", 16'(out_valid[1]), 16'h1);
    chk("x_data", 16'(out_data[1]), 16'(xval));
    in_valid = 1'b0; in_data = 4'h0; out_ready = 4'hF;
    tick();
    chk("x_drained", 16'(out_valid), 16'h0);

    // Reset mid-stream discards buffered words
    out_ready = 4'h0;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 4'h1;
    tick();
    in_sel = 2'd2; in_data = 4'h2;
    tick();
    in_sel = 2'd0; in_data = 4'h3;
    tick();
    chk("pre_rst_valid", 16'(out_valid), 16'h5);
    chk("pre_rst_ready", 16'(in_ready), 16'h0);
    in_valid = 1'b0; rst = 1'b1; out_ready = 4'hF;
    tick();
    chk("mid_rst_valid", 16'(out_valid), 16'h0);
    chk("mid_rst_ready", 16'(in_ready), 16'h1);
    chk("mid_rst_data", out_data, 16'h0000);
    rst = 1'b0;
    tick();
    tick();
    chk("post_rst_valid", 16'(out_valid), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
